conv_result_collector: RTL and testbench

Output-side counterpart of the packed-pixel convolver: consumes the 32-bit packed result words (NB_DATA/NB_PIXEL pixels per word) that the convolver emits alongside its input valid strobe. It discards the warm-up words produced before the kernel window is full, counts one frame of results, and buffers them in a first-word-fall-through (FWFT) FIFO. A downstream reader (AXI/GPIO bridge) drains the FIFO with a valid/ready handshake.

---
 rtl/conv_result_collector.sv | 187 ++++++++++++++++++
 tb/tb_conv_result_collector.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_collector.sv
// conv_result_collector
//
// Sits after the packed-pixel convolver. It drops the warm-up words that come
// out before the kernel window is full, counts one frame of result words, and
// buffers them in a first-word-fall-through FIFO. A downstream reader drains
// that FIFO with a valid/ready handshake.
//
// Optional build macro:
//   COLLECTOR_LANE_REVERSE_EN - when defined, pixel lanes are reversed as each
//                               word is pushed, so lane k ends up in lane
//                               LANES-1-k. When undefined, words are stored
//                               unchanged.
//
// Ports:
//   i_clk          clock; all logic on the rising edge
//   i_reset        asynchronous reset, active low
//   i_frame_start  one-cycle pulse; arms collection of a new frame
//   i_data         packed convolver result word
//   i_valid        qualifies i_data, one cycle per word
//   o_data         FIFO head word; 0 while the FIFO is empty
//   o_valid        FIFO is not empty
//   i_ready        reader accepts o_data when o_valid && i_ready
//   o_level        FIFO occupancy
//   o_busy         high while skipping or collecting
//   o_frame_done   one-cycle pulse after the last frame word is counted
//   o_overflow     sticky; a frame word was dropped because the FIFO was full

module conv_result_collector #(
    parameter int unsigned NB_DATA     = 32,
    parameter int unsigned NB_PIXEL    = 8,
    parameter int unsigned SKIP_WORDS  = 3,
    parameter int unsigned FRAME_WORDS = 6,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned NB_LEVEL    = 3
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_frame_start,
    input  logic [NB_DATA-1:0]  i_data,
    input  logic                i_valid,
    output logic [NB_DATA-1:0]  o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [NB_LEVEL-1:0] o_level,
    output logic                o_busy,
    output logic                o_frame_done,
    output logic                o_overflow
);

    localparam int unsigned NB_LANES = NB_DATA / NB_PIXEL;
    localparam int unsigned NB_ADDR  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned NB_PTR   = NB_ADDR + 1;
    localparam int unsigned NB_SKIP  = (SKIP_WORDS > 0) ? $clog2(SKIP_WORDS + 1) : 1;
    localparam int unsigned NB_FRAME = (FRAME_WORDS > 0) ? $clog2(FRAME_WORDS + 1) : 1;

    typedef enum logic [1:0] {StIdle, StSkip, StCollect, StDone} state_e;

    state_e              state_q;
    logic [NB_SKIP-1:0]  skip_cnt_q;
    logic [NB_FRAME-1:0] frame_cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                overflow_q;

    logic [NB_DATA-1:0]  mem_q [FIFO_DEPTH];
    logic [NB_PTR-1:0]   wptr_q;
    logic [NB_PTR-1:0]   rptr_q;
    logic [NB_PTR-1:0]   level;
    logic                empty;
    logic                full;
    logic                pop;
    logic                frame_word;
    logic                push;
    logic                drop;
    logic                last_skip;
    logic                last_frame;
    logic [NB_DATA-1:0]  push_data;

    // Pointers carry one extra wrap bit, so the difference is the occupancy.
    assign level = wptr_q - rptr_q;
    assign empty = (level == '0);
    assign full  = (level == NB_PTR'(FIFO_DEPTH));
    assign pop   = !empty && i_ready;

    // A frame start in the same cycle wins, and the word is ignored.
    assign frame_word = (state_q == StCollect) && i_valid && !i_frame_start;
    // A full FIFO still accepts a word when a pop frees a slot on the same edge.
    assign push       = frame_word && (!full || pop);
    assign drop       = frame_word && !push;

    assign last_skip  = (32'(skip_cnt_q) + 32'd1 == SKIP_WORDS);
    assign last_frame = (32'(frame_cnt_q) + 32'd1 == FRAME_WORDS);

`ifdef COLLECTOR_LANE_REVERSE_EN
    always_comb begin
        push_data = '0;
        for (int unsigned k = 0; k < NB_LANES; k++) begin
            push_data[(NB_LANES - 1 - k) * NB_PIXEL +: NB_PIXEL] = i_data[k * NB_PIXEL +: NB_PIXEL];
        end
    end
`else
    assign push_data = i_data;
`endif

    // Frame sequencing FSM. Outputs are registered alongside the state.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= StIdle;
            skip_cnt_q  <= '0;
            frame_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_frame_start) begin
                // Restart from any state. An active frame is aborted with no
                // done pulse, and the FIFO contents stay readable.
                skip_cnt_q  <= '0;
                frame_cnt_q <= '0;
                overflow_q  <= 1'b0;
                busy_q      <= 1'b1;
                state_q     <= (SKIP_WORDS > 0) ? StSkip : StCollect;
            end else begin
                unique case (state_q)
                    StSkip: begin
                        if (i_valid) begin
                            skip_cnt_q <= skip_cnt_q + 1'b1;
                            if (last_skip) begin
                                state_q <= StCollect;
                            end
                        end
                    end
                    StCollect: begin
                        if (i_valid) begin
                            // Dropped words still count, so frame alignment is kept.
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                            if (drop) begin
                                overflow_q <= 1'b1;
                            end
                            if (last_frame) begin
                                state_q <= StDone;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    StIdle, StDone: begin
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset; o_data is masked while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wptr_q[NB_ADDR-1:0]] <= push_data;
        end
    end

    assign o_data       = empty ? '0 : mem_q[rptr_q[NB_ADDR-1:0]];
    assign o_valid      = !empty;
    assign o_level      = NB_LEVEL'(level);
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Self-checking bench for conv_result_collector (default parameters).
// A queue-based reference model is compared against the DUT on every cycle.
// Table vectors and hand-written sequences also carry fixed expected values.

module tb_conv_result_collector;

    localparam int SKIP  = 3;
    localparam int FRAME = 6;
    localparam int DEPTH = 4;

    logic        i_clk;
    logic        i_reset;
    logic        i_frame_start;
    logic [31:0] i_data;
    logic        i_valid;
    logic [31:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic [2:0]  o_level;
    logic        o_busy;
    logic        o_frame_done;
    logic        o_overflow;

    conv_result_collector #(
        .NB_DATA     (32),
        .NB_PIXEL    (8),
        .SKIP_WORDS  (SKIP),
        .FRAME_WORDS (FRAME),
        .FIFO_DEPTH  (DEPTH),
        .NB_LEVEL    (3)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_frame_start (i_frame_start),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_level       (o_level),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done),
        .o_overflow    (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: words accepted since the last frame start decide their
    // own role (skip, frame, ignored). The FIFO is a plain queue.
    logic [31:0] mq[$];
    bit          armed;
    int          n_seen;
    bit          m_ovf;
    bit          m_done;

    function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef COLLECTOR_LANE_REVERSE_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        armed  = 1'b0;
        n_seen = 0;
        m_ovf  = 1'b0;
        m_done = 1'b0;
    endtask

    // Apply the inputs that are present at the coming rising edge.
    task automatic model_edge();
        bit do_pop;
        bit done_next;
        logic [31:0] pushed;
        bit do_push;
        do_pop    = (mq.size() > 0) && i_ready;
        done_next = 1'b0;
        do_push   = 1'b0;
        pushed    = '0;
        if (i_frame_start) begin
            armed  = 1'b1;
            n_seen = 0;
            m_ovf  = 1'b0;
        end else if (armed && i_valid && n_seen < SKIP + FRAME) begin
            if (n_seen >= SKIP) begin
                if (mq.size() < DEPTH || do_pop) begin
                    do_push = 1'b1;
                    pushed  = exp_word(i_data);
                end else begin
                    m_ovf = 1'b1;
                end
                if (n_seen == SKIP + FRAME - 1) done_next = 1'b1;
            end
            n_seen++;
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(pushed);
        m_done = done_next;
    endtask

    task automatic cmp_model();
        logic [31:0] head;
        head = (mq.size() > 0) ? mq[0] : 32'h0;
        chk("m_valid", {31'b0, o_valid}, {31'b0, mq.size() > 0});
        chk("m_data", o_data, head);
        chk("m_level", {29'b0, o_level}, mq.size());
        chk("m_busy", {31'b0, o_busy}, {31'b0, armed && (n_seen < SKIP + FRAME)});
        chk("m_done", {31'b0, o_frame_done}, {31'b0, m_done});
        chk("m_ovf", {31'b0, o_overflow}, {31'b0, m_ovf});
    endtask

    task automatic step();
        model_edge();
        @(posedge i_clk);
        #1;
        cmp_model();
    endtask

    task automatic drive(input bit fs, input bit v, input logic [31:0] d, input bit r);
        i_frame_start = fs;
        i_valid       = v;
        i_data        = d;
        i_ready       = r;
        step();
    endtask

    typedef struct {
        bit          fs;
        bit          v;
        logic [31:0] d;
        bit          r;
        int          lvl;
        logic [31:0] hd;
        bit          busy;
        bit          done;
        bit          ovf;
    } vec_t;

    vec_t tbl[14];

    initial begin
        i_reset       = 1'b1;
        i_frame_start = 1'b0;
        i_valid       = 1'b0;
        i_data        = '0;
        i_ready       = 1'b0;
        model_reset();

        // Reset state.
        #2 i_reset = 1'b0;
        #1;
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_level", {29'b0, o_level}, 32'd0);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_done", {31'b0, o_frame_done}, 32'd0);
        chk("rst_ovf", {31'b0, o_overflow}, 32'd0);
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b1;

        // Basic frame: three skipped words, then six frame words with a reader.
        tbl[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 0, 32'h0,        1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 32'hff000022, 1'b0, 0, 32'h0,        1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'h77ff1133, 1'b0, 0, 32'h0,        1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 32'h0011ff00, 1'b0, 0, 32'h0,        1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 32'h11111111, 1'b0, 1, 32'h11111111, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 32'h22445500, 1'b0, 2, 32'h11111111, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 32'h00000000, 1'b0, 3, 32'h11111111, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'haabbccdd, 1'b1, 3, 32'h22445500, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 32'h01020304, 1'b1, 3, 32'h00000000, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 32'h05060708, 1'b1, 3, 32'haabbccdd, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'hdeadbeef, 1'b1, 2, 32'h01020304, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'h12345678, 1'b1, 1, 32'h05060708, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 0, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 0, 32'h0,        1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].fs, tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d_level", i), {29'b0, o_level}, tbl[i].lvl);
            chk($sformatf("tbl%0d_data", i), o_data, exp_word(tbl[i].hd));
            chk($sformatf("tbl%0d_busy", i), {31'b0, o_busy}, {31'b0, tbl[i].busy});
            chk($sformatf("tbl%0d_done", i), {31'b0, o_frame_done}, {31'b0, tbl[i].done});
            chk($sformatf("tbl%0d_ovf", i), {31'b0, o_overflow}, {31'b0, tbl[i].ovf});
        end

        // Overflow: no reader, six frame words into a four-deep FIFO.
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, $urandom, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 1'b1, 32'(k), 1'b0);
            if (k == 5) chk("ovf_set_w5", {31'b0, o_overflow}, 32'd1);
        end
        chk("ovf_level", {29'b0, o_level}, 32'd4);
        chk("ovf_done", {31'b0, o_frame_done}, 32'd1);
        chk("ovf_sticky", {31'b0, o_overflow}, 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("ovf_done_once", {31'b0, o_frame_done}, 32'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        chk("ovf_cleared", {31'b0, o_overflow}, 32'd0);
        chk("ovf_no_flush", {29'b0, o_level}, 32'd4);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain%0d", k), o_data, exp_word(32'(k)));
            drive(1'b0, 1'b0, 32'h0, 1'b1);
        end
        chk("drain_empty", {31'b0, o_valid}, 32'd0);

        // Full FIFO with push and pop on the same edge, then a restart on a valid word.
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, $urandom, 1'b0);
        for (int k = 1; k <= 4; k++) drive(1'b0, 1'b1, 32'h100 + 32'(k), 1'b0);
        chk("full_level", {29'b0, o_level}, 32'd4);
        drive(1'b0, 1'b1, 32'h105, 1'b1);
        chk("pp_level", {29'b0, o_level}, 32'd4);
        chk("pp_ovf", {31'b0, o_overflow}, 32'd0);
        chk("pp_head", o_data, exp_word(32'h102));
        drive(1'b1, 1'b1, 32'h106, 1'b0);
        chk("rs_busy", {31'b0, o_busy}, 32'd1);
        chk("rs_level", {29'b0, o_level}, 32'd4);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 32'h200, 1'b0);
            chk("rs_skip_nodone", {31'b0, o_frame_done}, 32'd0);
            chk("rs_skip_noovf", {31'b0, o_overflow}, 32'd0);
        end
        drive(1'b0, 1'b1, 32'h201, 1'b0);
        chk("rs_collect_ovf", {31'b0, o_overflow}, 32'd1);

        // Asynchronous reset between edges with two words buffered.
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("ar_pre_level", {29'b0, o_level}, 32'd2);
        #2 i_reset = 1'b0;
        #1;
        model_reset();
        chk("ar_valid", {31'b0, o_valid}, 32'd0);
        chk("ar_data", o_data, 32'd0);
        chk("ar_level", {29'b0, o_level}, 32'd0);
        chk("ar_busy", {31'b0, o_busy}, 32'd0);
        chk("ar_ovf", {31'b0, o_overflow}, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        for (int k = 0; k < 12; k++) drive(1'b0, 1'b1, $urandom, 1'b1);
        chk("ar_idle_level", {29'b0, o_level}, 32'd0);

        // Randomised traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6, $urandom,
                  $urandom_range(0, 9) < ((c / 200) % 2 == 0 ? 3 : 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
